// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: baud prescaler, receiver sequencing FSM and receive buffer.
// Define UART_RX_FIFO_EN for a 2**DEPTH_LOG2 entry FIFO; otherwise a single holding register is used.
module uart_rx_ctrl #(
  parameter logic [15:0] DIV_RST    = 16'd53,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cfg_we,
  input  logic [21:0] i_cfg_wdata,
  output logic        o_rx_ce,
  output logic        o_rx_rst,
  output logic        o_rx_rst_err,
  output logic [1:0]  o_length,
  output logic        o_stop2,
  output logic        o_parity,
  output logic        o_odd,
  input  logic [8:0]  i_rx_data,
  input  logic        i_rx_busy,
  input  logic        i_rx_overrun,
  input  logic        i_rx_parity,
  input  logic        i_rd,
  output logic [8:0]  o_rd_data,
  output logic        o_rd_ferr,
  output logic        o_rd_perr,
  output logic        o_empty,
  output logic        o_full,
  output logic        o_drop_err,
  input  logic        i_err_clr,
  output logic        o_irq
);

  typedef enum logic [1:0] {S_RESET, S_IDLE, S_RECV, S_PUSH} state_t;

  state_t      state, state_nxt;
  logic        rst_cnt, rst_cnt_nxt;
  logic [15:0] div;
  logic [15:0] presc;
  logic [1:0]  length;
  logic        stop2, parity, odd, irq_en;
  logic        push, do_push, do_pop, drop;
  logic        fifo_empty, fifo_full;
  logic [10:0] head;
  logic        drop_err, irq;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div    <= DIV_RST;
      length <= 2'b11;
      stop2  <= 1'b0;
      parity <= 1'b0;
      odd    <= 1'b0;
      irq_en <= 1'b0;
    end else if (i_cfg_we) begin
      div    <= i_cfg_wdata[15:0];
      length <= i_cfg_wdata[17:16];
      stop2  <= i_cfg_wdata[18];
      parity <= i_cfg_wdata[19];
      odd    <= i_cfg_wdata[20];
      irq_en <= i_cfg_wdata[21];
    end
  end

  assign o_length = length;
  assign o_stop2  = stop2;
  assign o_parity = parity;
  assign o_odd    = odd;

  // Prescaler is held at zero while the receiver is in reset so it restarts cleanly after a config change.
  always_ff @(posedge i_clk) begin
    if (i_rst || state == S_RESET) begin
      presc <= 16'd0;
    end else if (presc == div) begin
      presc <= 16'd0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  assign o_rx_ce = ~i_rst & (state != S_RESET) & (presc == div);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_RESET;
      rst_cnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      rst_cnt <= rst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = 1'b0;
    case (state)
      S_RESET: begin
        rst_cnt_nxt = ~rst_cnt;
        if (rst_cnt) state_nxt = S_IDLE;
      end
      S_IDLE:  if (i_rx_busy) state_nxt = S_RECV;
      S_RECV:  if (!i_rx_busy) state_nxt = S_PUSH;
      S_PUSH:  state_nxt = S_IDLE;
      default: state_nxt = S_RESET;
    endcase
    // A config write aborts any frame in progress and restarts the receiver reset window.
    if (i_cfg_we) begin
      state_nxt   = S_RESET;
      rst_cnt_nxt = 1'b0;
    end
  end

  assign o_rx_rst     = i_rst | (state == S_RESET);
  assign o_rx_rst_err = ~i_rst & (state == S_PUSH);
  assign push         = (state == S_PUSH) & ~i_rst & ~i_cfg_we;

  // A push into a full buffer still succeeds when a pop frees the head in the same cycle.
  assign do_pop  = i_rd & ~fifo_empty;
  assign do_push = push & (~fifo_full | do_pop);
  assign drop    = push & fifo_full & ~do_pop;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [10:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign head       = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {i_rx_overrun, i_rx_parity, i_rx_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2 + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2 + 1)'(1);
    end
  end
`else
  logic [10:0] hold;
  logic        valid;

  // DEPTH_LOG2 has no effect on the single-register build.
  if (DEPTH_LOG2 < 0) begin : g_depth_log2_unused
  end

  assign fifo_empty = ~valid;
  assign fifo_full  = valid;
  assign head       = hold;

  always_ff @(posedge i_clk) begin
    if (do_push) hold <= {i_rx_overrun, i_rx_parity, i_rx_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) valid <= 1'b0;
    else       valid <= do_push | (valid & ~do_pop);
  end
`endif

  assign o_rd_ferr = head[10];
  assign o_rd_perr = head[9];
  assign o_rd_data = head[8:0];
  assign o_empty   = fifo_empty;
  assign o_full    = fifo_full;

  // A new drop wins over a simultaneous clear so the overflow is never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst)          drop_err <= 1'b0;
    else if (drop)      drop_err <= 1'b1;
    else if (i_err_clr) drop_err <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) irq <= 1'b0;
    else       irq <= (irq_en & ~fifo_empty) | drop_err;
  end

  assign o_drop_err = drop_err;
  assign o_irq      = irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl; expectations adapt to UART_RX_FIFO_EN (depth 4 or 1).
module tb_uart_rx_ctrl;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, cfg_we, rx_busy, rx_overrun, rx_parity, rd, err_clr;
  logic [21:0] cfg_wdata;
  logic [8:0]  rx_data;
  logic        rx_ce, rx_rst, rx_rst_err, stop2, parity, odd;
  logic [1:0]  length;
  logic [8:0]  rd_data;
  logic        rd_ferr, rd_perr, empty, full, drop_err, irq;

  int assert_count = 0;
  int fail_count   = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DIV_RST(16'd53), .DEPTH_LOG2(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_wdata(cfg_wdata),
    .o_rx_ce(rx_ce), .o_rx_rst(rx_rst), .o_rx_rst_err(rx_rst_err),
    .o_length(length), .o_stop2(stop2), .o_parity(parity), .o_odd(odd),
    .i_rx_data(rx_data), .i_rx_busy(rx_busy), .i_rx_overrun(rx_overrun),
    .i_rx_parity(rx_parity), .i_rd(rd), .o_rd_data(rd_data),
    .o_rd_ferr(rd_ferr), .o_rd_perr(rd_perr), .o_empty(empty), .o_full(full),
    .o_drop_err(drop_err), .i_err_clr(err_clr), .o_irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one received frame: busy for 10 cycles, then the push cycle (optionally with a pop).
  task automatic applyStimulus(input logic [8:0] data, input logic ovr, input logic par,
                               input logic pop_in_push, output logic empty_in_push);
    rx_data    = data;
    rx_overrun = ovr;
    rx_parity  = par;
    rx_busy    = 1'b1;
    repeat (10) tick();
    rx_busy = 1'b0;
    tick();
    checkOutput("rst_err_in_push", rx_rst_err, 1'b1);
    empty_in_push = empty;
    if (pop_in_push) rd = 1'b1;
    tick();
    rd         = 1'b0;
    rx_overrun = 1'b0;
    rx_parity  = 1'b0;
    checkOutput("rst_err_after_push", rx_rst_err, 1'b0);
  endtask

  task automatic doConfig(input logic [21:0] wdata);
    cfg_wdata = wdata;
    cfg_we    = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic popCheck(input string tag, input logic [8:0] expected);
    checkOutput(tag, rd_data, expected);
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    logic       e;
    logic [7:0] ce_bits;

    rst = 1'b1; cfg_we = 1'b0; cfg_wdata = '0; rx_busy = 1'b0; rx_overrun = 1'b0;
    rx_parity = 1'b0; rd = 1'b0; err_clr = 1'b0; rx_data = '0;
    repeat (2) tick();
    checkOutput("rst_rx_rst", rx_rst, 1'b1);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_drop", drop_err, 1'b0);
    checkOutput("rst_irq", irq, 1'b0);
    checkOutput("rst_ce", rx_ce, 1'b0);
    checkOutput("rst_rst_err", rx_rst_err, 1'b0);
    checkOutput("rst_cfg", {length, stop2, parity, odd}, 5'b11000);

    rst = 1'b0;
    checkOutput("reset_win_c0", rx_rst, 1'b1);
    tick();
    checkOutput("reset_win_c1", rx_rst, 1'b1);
    tick();
    checkOutput("reset_win_end", rx_rst, 1'b0);

    // Second write during the reset window restarts the 2-cycle count.
    doConfig(22'h030003);
    tick();
    doConfig(22'h030003);
    checkOutput("restart_c0", rx_rst, 1'b1);
    tick();
    checkOutput("restart_c1", rx_rst, 1'b1);
    tick();
    checkOutput("restart_end", rx_rst, 1'b0);

    ce_bits = '0;
    for (int i = 0; i < 8; i++) begin
      ce_bits[i] = rx_ce;
      tick();
    end
    checkOutput("ce_div3", ce_bits, 8'h88);

    doConfig(22'h030000);
    checkOutput("ce_held_in_reset", rx_ce, 1'b0);
    repeat (2) tick();
    ce_bits = '0;
    for (int i = 0; i < 8; i++) begin
      ce_bits[i] = rx_ce;
      tick();
    end
    checkOutput("ce_div0", ce_bits, 8'hFF);

    applyStimulus(9'h0A5, 1'b0, 1'b0, 1'b0, e);
    checkOutput("empty_in_push", e, 1'b1);
    checkOutput("empty_after_push", empty, 1'b0);
    checkOutput("frame_data", rd_data, 9'h0A5);
    checkOutput("frame_tags", {rd_ferr, rd_perr}, 2'b00);
    popCheck("frame_pop", 9'h0A5);
    checkOutput("frame_drained", empty, 1'b1);

    applyStimulus(9'h1FF, 1'b0, 1'b1, 1'b0, e);
    checkOutput("perr_tags", {rd_ferr, rd_perr}, 2'b01);
    popCheck("perr_pop", 9'h1FF);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checkOutput("rd_empty_status", {empty, full}, 2'b10);
    applyStimulus(9'h033, 1'b1, 1'b0, 1'b0, e);
    checkOutput("ferr_tags", {rd_ferr, rd_perr}, 2'b10);
    popCheck("after_empty_rd", 9'h033);

    for (int i = 0; i <= DEPTH; i++) applyStimulus(9'h010 + 9'(i), 1'b0, 1'b0, 1'b0, e);
    checkOutput("ovf_full", full, 1'b1);
    checkOutput("ovf_drop", drop_err, 1'b1);
    tick();
    checkOutput("ovf_irq", irq, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("clr_drop", drop_err, 1'b0);
    checkOutput("clr_keeps_full", full, 1'b1);
    for (int i = 0; i < DEPTH; i++) popCheck("ovf_order", 9'h010 + 9'(i));
    checkOutput("ovf_drained", empty, 1'b1);

    for (int i = 0; i < DEPTH; i++) applyStimulus(9'h020 + 9'(i), 1'b0, 1'b0, 1'b0, e);
    checkOutput("simul_pre_full", full, 1'b1);
    applyStimulus(9'h0AA, 1'b0, 1'b0, 1'b1, e);
    checkOutput("simul_full", full, 1'b1);
    checkOutput("simul_drop", drop_err, 1'b0);
    exp_q.delete();
    for (int i = 1; i < DEPTH; i++) exp_q.push_back(9'h020 + 9'(i));
    exp_q.push_back(9'h0AA);
    while (exp_q.size() > 0) popCheck("simul_order", exp_q.pop_front());
    checkOutput("simul_drained", empty, 1'b1);

    rx_data = 9'h155;
    rx_busy = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rx_busy = 1'b0;
    rst = 1'b0;
    repeat (4) tick();
    checkOutput("midframe_rst_empty", empty, 1'b1);
    checkOutput("midframe_rst_cfg", {length, stop2, parity, odd}, 5'b11000);

    rx_busy = 1'b1;
    repeat (3) tick();
    doConfig(22'h2F0007);
    checkOutput("cfg_recv_rst0", rx_rst, 1'b1);
    tick();
    rx_busy = 1'b0;
    checkOutput("cfg_recv_rst1", rx_rst, 1'b1);
    tick();
    checkOutput("cfg_recv_rst_end", rx_rst, 1'b0);
    repeat (3) begin
      checkOutput("cfg_no_push_err", rx_rst_err, 1'b0);
      tick();
    end
    checkOutput("cfg_no_push", empty, 1'b1);
    checkOutput("cfg_fields", {length, stop2, parity, odd}, 5'b11110);
    checkOutput("cfg_irq_idle", irq, 1'b0);
    applyStimulus(9'h07E, 1'b0, 1'b0, 1'b0, e);
    checkOutput("irq_lag", irq, 1'b0);
    tick();
    checkOutput("irq_en_set", irq, 1'b1);
    popCheck("irq_pop", 9'h07E);
    checkOutput("irq_hold", irq, 1'b1);
    tick();
    checkOutput("irq_clear", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
